// File: rtl/mult_led_sequencer_if.sv
// Control and display bundle for the multiplying LED sequencer.
// The master drives start/stop/loop; the sequencer drives the display side.
interface mult_led_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int COUNT = 4
);
    logic                     start;
    logic                     stop;
    logic                     loop;
    logic [WIDTH-1:0]         led;
    logic [$clog2(COUNT)-1:0] idx;
    logic                     busy;
    logic                     done;
    logic                     err;

    modport master (
        output start, stop, loop,
        input  led, idx, busy, done, err
    );

    modport slave (
        input  start, stop, loop,
        output led, idx, busy, done, err
    );
endinterface

// File: rtl/mult_led_sequencer.sv
// Steps an index through COUNT entries, showing idx*STEP on the LEDs
// for DIV clocks per entry; saturates to all ones with err on overflow.
module mult_led_sequencer #(
    parameter int WIDTH = 4,
    parameter int STEP  = 3,
    parameter int COUNT = 4,
    parameter int DIV   = 4
) (
    input logic            clk,
    input logic            rst,
    mult_led_sequencer_if.slave bus
);
    localparam int IW = $clog2(COUNT);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [15:0]      presc;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] led_q;
    logic             err_q;
    logic             done_q;
    logic             busy_q;
    logic             lp_q;

    logic             tick;
    logic             last;
    logic [IW-1:0]    nidx;
    logic [31:0]      v;
    logic [WIDTH-1:0] nled;
    logic             nerr;

    assign tick = (presc == 16'(DIV - 1));
    assign last = (idx_q == IW'(COUNT - 1));
    assign nidx = idx_q + IW'(1);
    assign v    = 32'(nidx) * 32'(STEP);

    // Display value for the entry being entered on this tick
    always_comb begin
        nled = '1;
        nerr = 1'b1;
        if (v < (32'd1 << WIDTH)) begin
            nled = v[WIDTH-1:0];
            nerr = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            presc  <= '0;
            idx_q  <= '0;
            led_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            lp_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        presc  <= '0;
                        idx_q  <= '0;
                        led_q  <= '0;
                        err_q  <= 1'b0;
                        lp_q   <= bus.loop;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (tick) begin
                        presc <= '0;
                        if (!last) begin
                            idx_q <= nidx;
                            led_q <= nled;
                            err_q <= nerr;
                        end else begin
                            done_q <= 1'b1;
                            if (lp_q) begin
                                idx_q <= '0;
                                led_q <= '0;
                                err_q <= 1'b0;
                            end else begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end
                        end
                    end else begin
                        presc <= presc + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.led  = led_q;
    assign bus.idx  = idx_q;
    assign bus.err  = err_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_mult_led_sequencer.sv
// Bench for mult_led_sequencer: three parameterisations driven in lockstep
// and compared with an entry/dwell model plus directed scenario checks.
module tb_mult_led_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_led_sequencer_if #(.WIDTH(4), .COUNT(4)) if0 ();
    mult_led_sequencer_if #(.WIDTH(4), .COUNT(4)) if1 ();
    mult_led_sequencer_if #(.WIDTH(4), .COUNT(2)) if2 ();

    mult_led_sequencer dut0 (.clk(clk), .rst(rst), .bus(if0));
    mult_led_sequencer #(.STEP(6)) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );
    mult_led_sequencer #(.COUNT(2), .DIV(1)) dut2 (
        .clk(clk), .rst(rst), .bus(if2)
    );

    localparam int PSTEP  [3] = '{3, 6, 3};
    localparam int PCOUNT [3] = '{4, 4, 2};
    localparam int PDIV   [3] = '{4, 4, 1};

    typedef struct {
        bit run;
        bit lp;
        int k;
        int t;
        bit done;
    } mdl_t;

    mdl_t m [3];
    int checks = 0;
    int errors = 0;

    logic [3:0] dled  [3];
    logic [7:0] didx  [3];
    logic       dbusy [3];
    logic       ddone [3];
    logic       derr  [3];

    assign dled[0] = if0.led;
    assign dled[1] = if1.led;
    assign dled[2] = if2.led;
    assign didx[0] = 8'(if0.idx);
    assign didx[1] = 8'(if1.idx);
    assign didx[2] = 8'(if2.idx);
    assign dbusy[0] = if0.busy;
    assign dbusy[1] = if1.busy;
    assign dbusy[2] = if2.busy;
    assign ddone[0] = if0.done;
    assign ddone[1] = if1.done;
    assign ddone[2] = if2.done;
    assign derr[0] = if0.err;
    assign derr[1] = if1.err;
    assign derr[2] = if2.err;

    // Entry k is shown for div cycles (t counts them); led is a pure
    // function of k, which also holds across abort and one-shot end.
    function automatic mdl_t step(mdl_t c, bit r, bit s, bit p,
                                  bit l, int d);
        mdl_t n = c;
        n.done = 1'b0;
        if (r) begin
            n.run = 1'b0;
            n.k = 0;
            n.t = 0;
        end else if (!c.run) begin
            if (s && !p) begin
                n.run = 1'b1;
                n.k = 0;
                n.t = 0;
                n.lp = l;
            end
        end else if (p) begin
            n.run = 1'b0;
        end else if (c.t == PDIV[d] - 1) begin
            n.t = 0;
            if (c.k < PCOUNT[d] - 1) begin
                n.k = c.k + 1;
            end else begin
                n.done = 1'b1;
                if (c.lp) n.k = 0;
                else n.run = 1'b0;
            end
        end else begin
            n.t = c.t + 1;
        end
        return n;
    endfunction

    function automatic logic [14:0] want(int d);
        int v;
        int ld;
        v = m[d].k * PSTEP[d];
        ld = (v > 15) ? 15 : v;
        return {4'(ld), 8'(m[d].k), 1'(m[d].run),
                1'(m[d].done), 1'(v > 15)};
    endfunction

    function automatic logic [14:0] got(int d);
        return {dled[d], didx[d], dbusy[d], ddone[d], derr[d]};
    endfunction

    task automatic drive(bit r, bit s, bit p, bit l);
        rst = r;
        if0.start = s; if1.start = s; if2.start = s;
        if0.stop  = p; if1.stop  = p; if2.stop  = p;
        if0.loop  = l; if1.loop  = l; if2.loop  = l;
        @(posedge clk);
        for (int d = 0; d < 3; d++) m[d] = step(m[d], r, s, p, l, d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (got(d) !== 15'd0) begin
                errors++;
                $display("FAIL reset dut%0d got %h want %h",
                         d, got(d), 15'd0);
            end
        end
    endtask

    task automatic test_oneshot();
        int nd [3];
        int el;
        nd = '{0, 0, 0};
        for (int n = 0; n < 30; n++) begin
            drive(0, n == 0, 0, 0);
            for (int d = 0; d < 3; d++) begin
                nd[d] += int'(ddone[d]);
                checks++;
                if (got(d) !== want(d)) begin
                    errors++;
                    $display("FAIL oneshot_model dut%0d n=%0d got %h want %h",
                             d, n, got(d), want(d));
                end
            end
            el = (n < 16) ? 3 * (n / 4) : 9;
            checks++;
            if (dled[0] !== 4'(el)) begin
                errors++;
                $display("FAIL oneshot_led n=%0d got %h want %h",
                         n, dled[0], 4'(el));
            end
            checks++;
            if (derr[1] !== 1'(n >= 12)) begin
                errors++;
                $display("FAIL overflow_err n=%0d got %b want %b",
                         n, derr[1], n >= 12);
            end
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (nd[d] !== 1) begin
                errors++;
                $display("FAIL oneshot_done dut%0d got %0d want 1",
                         d, nd[d]);
            end
        end
        checks++;
        if ({dled[1], didx[1], dbusy[1]} !== {4'hf, 8'd3, 1'b0}) begin
            errors++;
            $display("FAIL overflow_hold got %h/%0d/%b want f/3/0",
                     dled[1], didx[1], dbusy[1]);
        end
    endtask

    task automatic test_loop();
        int nd [3];
        int exp_nd [3];
        nd = '{0, 0, 0};
        exp_nd = '{2, 2, 20};
        drive(0, 1, 0, 1);
        for (int n = 0; n < 40; n++) begin
            drive(0, 0, 0, 0);
            for (int d = 0; d < 3; d++) begin
                nd[d] += int'(ddone[d]);
                checks++;
                if (got(d) !== want(d)) begin
                    errors++;
                    $display("FAIL loop_model dut%0d n=%0d got %h want %h",
                             d, n, got(d), want(d));
                end
            end
            checks++;
            if (dbusy[0] !== 1'b1) begin
                errors++;
                $display("FAIL loop_busy n=%0d got %b want 1", n, dbusy[0]);
            end
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (nd[d] !== exp_nd[d]) begin
                errors++;
                $display("FAIL loop_done dut%0d got %0d want %0d",
                         d, nd[d], exp_nd[d]);
            end
        end
        drive(0, 0, 1, 0);
    endtask

    task automatic test_abort();
        int nd;
        nd = 0;
        drive(0, 1, 0, 0);
        for (int n = 0; n < 9; n++) begin
            drive(0, 0, 0, 0);
            nd += int'(ddone[0]);
        end
        drive(0, 0, 1, 0);
        nd += int'(ddone[0]);
        checks++;
        if (got(0) !== {4'd6, 8'd2, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_hold got %h want %h",
                     got(0), {4'd6, 8'd2, 3'b000});
        end
        drive(0, 0, 0, 0);
        nd += int'(ddone[0]);
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL abort_done got %0d want 0", nd);
        end
        drive(0, 1, 0, 0);
        checks++;
        if ({dled[0], didx[0], dbusy[0]} !== {4'd0, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL abort_restart got %h/%0d/%b want 0/0/1",
                     dled[0], didx[0], dbusy[0]);
        end
        drive(0, 0, 1, 0);
    endtask

    task automatic test_start_stop_idle();
        drive(0, 1, 1, 1);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (dbusy[d] !== 1'b0 || got(d) !== want(d)) begin
                errors++;
                $display("FAIL start_stop_idle dut%0d got %h want %h",
                         d, got(d), want(d));
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 0, 1);
        for (int n = 0; n < 4; n++) drive(0, 0, 0, 0);
        checks++;
        if (didx[0] !== 8'd1) begin
            errors++;
            $display("FAIL reset_mid_pre got %0d want 1", didx[0]);
        end
        for (int n = 0; n < 3; n++) begin
            drive(1, 1, 0, 0);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (got(d) !== 15'd0) begin
                    errors++;
                    $display("FAIL reset_mid dut%0d got %h want 0",
                             d, got(d));
                end
            end
        end
        drive(0, 1, 0, 0);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({dbusy[d], didx[d]} !== {1'b1, 8'd0}) begin
                errors++;
                $display("FAIL reset_release dut%0d got %b/%0d want 1/0",
                         d, dbusy[d], didx[d]);
            end
        end
        drive(0, 0, 1, 0);
    endtask

    task automatic test_random();
        bit r, s, p, l;
        for (int n = 0; n < 1500; n++) begin
            r = ($urandom_range(0, 127) == 0);
            s = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 39) == 0);
            l = 1'($urandom);
            drive(r, s, p, l);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (got(d) !== want(d)) begin
                    errors++;
                    $display("FAIL random dut%0d n=%0d got %h want %h",
                             d, n, got(d), want(d));
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) m[d] = '{0, 0, 0, 0, 0};
        rst = 1'b1;
        if0.start = 0; if1.start = 0; if2.start = 0;
        if0.stop  = 0; if1.stop  = 0; if2.stop  = 0;
        if0.loop  = 0; if1.loop  = 0; if2.loop  = 0;
        @(negedge clk);
        test_reset();
        test_oneshot();
        test_loop();
        test_abort();
        test_start_stop_idle();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
